// File: rtl/vga_frame_scanout.sv
// 640x480@60 VGA scan-out of an 8-bit grayscale frame buffer. The zoomed image is centred
// and surrounded by a border level. RAM addresses are built incrementally, without multipliers.
module vga_frame_scanout #(
  parameter int         H_VIS  = 640,
  parameter int         H_FP   = 16,
  parameter int         H_SYNC = 96,
  parameter int         H_BP   = 48,
  parameter int         V_VIS  = 480,
  parameter int         V_FP   = 10,
  parameter int         V_SYNC = 2,
  parameter int         V_BP   = 33,
  parameter logic [7:0] BORDER = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [1:0]  zoom_select,
  input  logic        busy,
  output logic [18:0] ram_rd_addr,
  input  logic [7:0]  ram_rd_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam logic [9:0] H_MAX    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  // Quarter, half and full-size image geometry, centred on the visible area.
  localparam logic [9:0] W_Q = 10'(H_VIS / 4);
  localparam logic [9:0] H_Q = 10'(V_VIS / 4);
  localparam logic [9:0] X_Q = 10'((H_VIS - H_VIS / 4) / 2);
  localparam logic [9:0] Y_Q = 10'((V_VIS - V_VIS / 4) / 2);
  localparam logic [9:0] W_H = 10'(H_VIS / 2);
  localparam logic [9:0] H_H = 10'(V_VIS / 2);
  localparam logic [9:0] X_H = 10'((H_VIS - H_VIS / 2) / 2);
  localparam logic [9:0] Y_H = 10'((V_VIS - V_VIS / 2) / 2);

  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]  size_q;
  logic        hold_q;
  logic [18:0] row_base_q;
  logic        frame_start_q;

  logic [9:0]  img_w_p0, img_h_p0, x_off_p0, y_off_p0, x_rel_p0;
  logic [10:0] x_end_p0, y_end_p0;
  logic        line_end_p0, frame_end_p0, in_x_p0, in_y_p0, in_img_p0;
  logic        hs_p0, vs_p0, act_p0;
  logic [18:0] addr_p0;

  logic [18:0] addr_p1_q;
  logic        hs_p1_q, vs_p1_q, act_p1_q, in_img_p1_q;

  logic        hs_p2_q, vs_p2_q, blank_n_p2_q;
  logic [7:0]  gray_p2_q;

  function automatic logic [7:0] pick_pixel(input logic act, input logic in_img,
                                            input logic hold, input logic [7:0] data);
    if (!act)
      return 8'h00;
    else if (in_img)
      return hold ? 8'h00 : data;
    else
      return BORDER;
  endfunction

  // ---- stage 0: counters, geometry and address arithmetic ----
  always_comb begin
    img_w_p0 = W_Q;
    img_h_p0 = H_Q;
    x_off_p0 = X_Q;
    y_off_p0 = Y_Q;
    case (size_q)
      2'b01: begin
        img_w_p0 = W_H;
        img_h_p0 = H_H;
        x_off_p0 = X_H;
        y_off_p0 = Y_H;
      end
      2'b10: begin
        img_w_p0 = H_VIS_C;
        img_h_p0 = V_VIS_C;
        x_off_p0 = '0;
        y_off_p0 = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    line_end_p0  = (h_cnt_q == H_MAX);
    frame_end_p0 = line_end_p0 && (v_cnt_q == V_MAX);
    h_cnt_d      = line_end_p0 ? '0 : h_cnt_q + 10'd1;
    v_cnt_d      = v_cnt_q;
    if (line_end_p0)
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1;
    hs_p0     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_p0     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    act_p0    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    x_end_p0  = {1'b0, x_off_p0} + {1'b0, img_w_p0};
    y_end_p0  = {1'b0, y_off_p0} + {1'b0, img_h_p0};
    in_x_p0   = (h_cnt_q >= x_off_p0) && ({1'b0, h_cnt_q} < x_end_p0);
    in_y_p0   = (v_cnt_q >= y_off_p0) && ({1'b0, v_cnt_q} < y_end_p0);
    in_img_p0 = in_x_p0 && in_y_p0;
    x_rel_p0  = h_cnt_q - x_off_p0;
    addr_p0   = in_img_p0 ? row_base_q + {9'd0, x_rel_p0} : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      size_q     <= 2'b00;
      hold_q     <= 1'b0;
      row_base_q <= '0;
    end else if (pix_en) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      // Image size and hold are sampled only at the frame boundary so a frame never tears.
      if (frame_end_p0) begin
        size_q     <= zoom_select;
        hold_q     <= busy;
        row_base_q <= '0;
      end else if (line_end_p0 && in_y_p0) begin
        row_base_q <= row_base_q + {9'd0, img_w_p0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_start_q <= 1'b0;
    else
      frame_start_q <= pix_en && frame_end_p0;
  end

  // ---- stage 1: RAM address and timing flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p1_q   <= '0;
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
      act_p1_q    <= 1'b0;
      in_img_p1_q <= 1'b0;
    end else if (pix_en) begin
      addr_p1_q   <= addr_p0;
      hs_p1_q     <= hs_p0;
      vs_p1_q     <= vs_p0;
      act_p1_q    <= act_p0;
      in_img_p1_q <= in_img_p0;
    end
  end

  // ---- stage 2: RAM data joins the delayed sync/blank ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_p2_q      <= 1'b1;
      vs_p2_q      <= 1'b1;
      blank_n_p2_q <= 1'b0;
      gray_p2_q    <= 8'h00;
    end else if (pix_en) begin
      hs_p2_q      <= hs_p1_q;
      vs_p2_q      <= vs_p1_q;
      blank_n_p2_q <= act_p1_q;
      gray_p2_q    <= pick_pixel(act_p1_q, in_img_p1_q, hold_q, ram_rd_data);
    end
  end

  assign ram_rd_addr = addr_p1_q;
  assign vga_hs      = hs_p2_q;
  assign vga_vs      = vs_p2_q;
  assign vga_blank_n = blank_n_p2_q;
  assign vga_r       = gray_p2_q;
  assign vga_g       = gray_p2_q;
  assign vga_b       = gray_p2_q;
  assign frame_start = frame_start_q;

endmodule
